// File: rtl/shared_add_arbiter.sv
// Round-robin arbiter and sequencer that time-shares one 2-cycle registered adder
// among NUM_REQ requesters and returns ID-tagged results on a single response channel.
module shared_add_arbiter #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned NUM_REQ    = 4,
    localparam int unsigned ID_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                          Clk_CI,
    input  logic                          Rst_RBI,
    input  logic [NUM_REQ-1:0]            ReqValid_SI,
    output logic [NUM_REQ-1:0]            ReqReady_SO,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] ReqA_DI,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] ReqB_DI,
    input  logic [NUM_REQ-1:0]            ReqCin_DI,
    output logic                          RspValid_SO,
    input  logic                          RspReady_SI,
    output logic [ID_WIDTH-1:0]           RspId_DO,
    output logic [DATA_WIDTH-1:0]         RspSum_DO,
    output logic                          RspCout_DO,
    output logic                          AddWrEn_SO,
    output logic [DATA_WIDTH-1:0]         AddA_DO,
    output logic [DATA_WIDTH-1:0]         AddB_DO,
    output logic                          AddCin_DO,
    input  logic [DATA_WIDTH-1:0]         AddSum_DI,
    input  logic                          AddCout_DI,
    output logic                          Busy_SO
);

    logic [ID_WIDTH-1:0] ptr_q, ptr_d;
    logic                v1_q, v1_d;
    logic [ID_WIDTH-1:0] id1_q, id1_d;
    logic                v2_q, v2_d;
    logic [ID_WIDTH-1:0] id2_q, id2_d;

    logic                stall;
    logic                any_valid;
    logic                issue;
    logic [ID_WIDTH-1:0] gnt;

    // A pending response that is not taken freezes the adder and both tag stages.
    assign stall = v2_q & ~RspReady_SI;
    assign issue = any_valid & ~stall;

    // Search starts one past the last winner so the last winner has lowest priority.
    always_comb begin
        int unsigned idx;
        gnt       = '0;
        any_valid = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(ptr_q) + 32'd1 + k) % NUM_REQ;
            if (!any_valid && ReqValid_SI[idx]) begin
                any_valid = 1'b1;
                gnt       = ID_WIDTH'(idx);
            end
        end
    end

    always_comb begin
        ReqReady_SO = '0;
        if (issue) begin
            ReqReady_SO[gnt] = 1'b1;
        end
    end

    always_comb begin
        AddA_DO   = '0;
        AddB_DO   = '0;
        AddCin_DO = 1'b0;
        if (any_valid) begin
            AddA_DO   = ReqA_DI[32'(gnt)*DATA_WIDTH +: DATA_WIDTH];
            AddB_DO   = ReqB_DI[32'(gnt)*DATA_WIDTH +: DATA_WIDTH];
            AddCin_DO = ReqCin_DI[gnt];
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        v1_d  = v1_q;
        id1_d = id1_q;
        v2_d  = v2_q;
        id2_d = id2_q;
        if (!stall) begin
            v1_d  = issue;
            id1_d = gnt;
            v2_d  = v1_q;
            id2_d = id1_q;
            if (issue) begin
                ptr_d = gnt;
            end
        end
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            ptr_q <= ID_WIDTH'(NUM_REQ - 1);
            v1_q  <= 1'b0;
            id1_q <= '0;
            v2_q  <= 1'b0;
            id2_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            v1_q  <= v1_d;
            id1_q <= id1_d;
            v2_q  <= v2_d;
            id2_q <= id2_d;
        end
    end

    assign AddWrEn_SO  = ~stall;
    assign RspValid_SO = v2_q;
    assign RspId_DO    = id2_q;
    assign RspSum_DO   = AddSum_DI;
    assign RspCout_DO  = AddCout_DI;
    assign Busy_SO     = v1_q | v2_q;

endmodule

// File: tb/tb_shared_add_arbiter.sv
// Bench for shared_add_arbiter: models the shared 2-stage adder locally, checks grants
// against a vector table and results against a scoreboard fed at request acceptance.
module tb_shared_add_arbiter;

    localparam int unsigned DW   = 12;
    localparam int unsigned NR   = 4;
    localparam int unsigned IDW  = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR*DW-1:0] req_a;
    logic [NR*DW-1:0] req_b;
    logic [NR-1:0]    req_cin;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IDW-1:0]   rsp_id;
    logic [DW-1:0]    rsp_sum;
    logic             rsp_cout;
    logic             add_wren;
    logic [DW-1:0]    add_a;
    logic [DW-1:0]    add_b;
    logic             add_cin;
    logic [DW-1:0]    add_sum_q;
    logic             add_cout_q;
    logic             busy;

    logic [DW-1:0]    add_a_q;
    logic [DW-1:0]    add_b_q;
    logic             add_cin_q;

    always #5 clk = ~clk;

    shared_add_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR)
    ) dut (
        .Clk_CI      (clk),
        .Rst_RBI     (rst_n),
        .ReqValid_SI (req_valid),
        .ReqReady_SO (req_ready),
        .ReqA_DI     (req_a),
        .ReqB_DI     (req_b),
        .ReqCin_DI   (req_cin),
        .RspValid_SO (rsp_valid),
        .RspReady_SI (rsp_ready),
        .RspId_DO    (rsp_id),
        .RspSum_DO   (rsp_sum),
        .RspCout_DO  (rsp_cout),
        .AddWrEn_SO  (add_wren),
        .AddA_DO     (add_a),
        .AddB_DO     (add_b),
        .AddCin_DO   (add_cin),
        .AddSum_DI   (add_sum_q),
        .AddCout_DI  (add_cout_q),
        .Busy_SO     (busy)
    );

    // Shared adder: input registers, then output registers, both gated by write-enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_a_q    <= '0;
            add_b_q    <= '0;
            add_cin_q  <= 1'b0;
            add_sum_q  <= '0;
            add_cout_q <= 1'b0;
        end else if (add_wren) begin
            add_a_q                  <= add_a;
            add_b_q                  <= add_b;
            add_cin_q                <= add_cin;
            {add_cout_q, add_sum_q}  <= {1'b0, add_a_q} + {1'b0, add_b_q} + {12'd0, add_cin_q};
        end
    end

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [DW:0]    cs;
    } sb_t;

    typedef struct packed {
        logic [NR-1:0] valid;
        logic          rdy;
        logic [NR-1:0] exp_ready;
        logic          exp_wren;
    } vec_t;

    sb_t           sb[$];
    vec_t          vq[$];
    logic [NR-1:0] acc_mask;
    int            n_cmp;
    int            n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pops/compares delivered results and records newly accepted requests.
    task automatic monitor();
        sb_t e;
        acc_mask = '0;
        if (!rst_n) return;
        if (rsp_valid && rsp_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected: got id %0d sum 0x%0h, required no response",
                         rsp_id, rsp_sum);
            end else begin
                e = sb.pop_front();
                if (rsp_id !== e.id || {rsp_cout, rsp_sum} !== e.cs) begin
                    n_fail++;
                    $display("FAIL rsp: got id %0d cout/sum 0x%0h required id %0d cout/sum 0x%0h",
                             rsp_id, {rsp_cout, rsp_sum}, e.id, e.cs);
                end
            end
        end
        acc_mask = req_valid & req_ready;
        for (int i = 0; i < NR; i++) begin
            if (acc_mask[i]) begin
                e.id = IDW'(i);
                e.cs = {1'b0, req_a[i*DW +: DW]} + {1'b0, req_b[i*DW +: DW]} +
                       {12'd0, req_cin[i]};
                sb.push_back(e);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (acc_mask[i]) begin
                req_a[i*DW +: DW] = DW'($urandom);
                req_b[i*DW +: DW] = DW'($urandom);
                req_cin[i]        = 1'($urandom);
            end
        end
    endtask

    task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic c);
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
        req_cin[i]        = c;
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        acc_mask  = '0;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < NR; i++) set_op(i, DW'($urandom), DW'($urandom), 1'($urandom));

        // Reset state
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_wren", 32'(add_wren), 1);
        check("rst_add_a", 32'(add_a), 0);
        check("rst_add_b", 32'(add_b), 0);
        check("rst_add_cin", 32'(add_cin), 0);
        rst_n = 1'b1;

        // Single request, 2-cycle latency
        set_op(1, 12'h123, 12'h0FF, 1'b1);
        req_valid = 4'b0010;
        #1 check("single_ready", 32'(req_ready), 32'b0010);
        check("single_add_a", 32'(add_a), 32'h123);
        step();
        req_valid = '0;
        check("single_c1_valid", 32'(rsp_valid), 0);
        check("single_c1_busy", 32'(busy), 1);
        step();
        check("single_c2_valid", 32'(rsp_valid), 1);
        check("single_c2_id", 32'(rsp_id), 1);
        check("single_c2_sum", 32'(rsp_sum), 32'h223);
        check("single_c2_cout", 32'(rsp_cout), 0);
        step();
        check("single_c3_busy", 32'(busy), 0);
        check("single_c3_valid", 32'(rsp_valid), 0);

        // Overflow
        set_op(0, 12'hFFF, 12'h001, 1'b0);
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        step();
        check("ovf_valid", 32'(rsp_valid), 1);
        check("ovf_id", 32'(rsp_id), 0);
        check("ovf_sum", 32'(rsp_sum), 0);
        check("ovf_cout", 32'(rsp_cout), 1);
        step();

        // Backpressure with two operations in flight
        set_op(0, 12'h010, 12'h020, 1'b0);
        req_valid = 4'b0001;
        #1 check("bp_ready0", 32'(req_ready), 32'b0001);
        step();
        set_op(1, 12'h100, 12'h200, 1'b1);
        req_valid = 4'b0010;
        #1 check("bp_ready1", 32'(req_ready), 32'b0010);
        step();
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp_hold_valid", 32'(rsp_valid), 1);
            check("bp_hold_id", 32'(rsp_id), 0);
            check("bp_hold_sum", 32'(rsp_sum), 32'h030);
            check("bp_hold_cout", 32'(rsp_cout), 0);
            check("bp_hold_wren", 32'(add_wren), 0);
            check("bp_hold_ready", 32'(req_ready), 0);
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        #1 check("bp_rel_wren", 32'(add_wren), 1);
        check("bp_rel_id", 32'(rsp_id), 0);
        step();
        check("bp_second_valid", 32'(rsp_valid), 1);
        check("bp_second_id", 32'(rsp_id), 1);
        check("bp_second_sum", 32'(rsp_sum), 32'h301);
        check("bp_second_cout", 32'(rsp_cout), 0);
        step();
        check("bp_after_valid", 32'(rsp_valid), 0);

        // Asynchronous reset with both stages occupied
        req_valid = 4'b1111;
        step();
        step();
        check("ar_pre_busy", 32'(busy), 1);
        check("ar_pre_valid", 32'(rsp_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_rsp_valid", 32'(rsp_valid), 0);
        check("ar_busy", 32'(busy), 0);
        sb.delete();
        acc_mask = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Grant table from the reset pointer: rotation, skips, fairness, stall
        vq.push_back('{4'b1111, 1'b1, 4'b0001, 1'b1});
        vq.push_back('{4'b1111, 1'b1, 4'b0010, 1'b1});
        vq.push_back('{4'b1111, 1'b1, 4'b0100, 1'b1});
        vq.push_back('{4'b1111, 1'b1, 4'b1000, 1'b1});
        vq.push_back('{4'b1111, 1'b1, 4'b0001, 1'b1});
        vq.push_back('{4'b1111, 1'b1, 4'b0010, 1'b1});
        vq.push_back('{4'b0000, 1'b1, 4'b0000, 1'b1});
        vq.push_back('{4'b0001, 1'b1, 4'b0001, 1'b1});
        vq.push_back('{4'b1001, 1'b1, 4'b1000, 1'b1});
        vq.push_back('{4'b1001, 1'b1, 4'b0001, 1'b1});
        vq.push_back('{4'b0110, 1'b1, 4'b0010, 1'b1});
        vq.push_back('{4'b0110, 1'b1, 4'b0100, 1'b1});
        vq.push_back('{4'b0110, 1'b1, 4'b0010, 1'b1});
        vq.push_back('{4'b1100, 1'b1, 4'b0100, 1'b1});
        vq.push_back('{4'b1100, 1'b1, 4'b1000, 1'b1});
        vq.push_back('{4'b1100, 1'b1, 4'b0100, 1'b1});
        vq.push_back('{4'b1100, 1'b1, 4'b1000, 1'b1});
        vq.push_back('{4'b1101, 1'b1, 4'b0001, 1'b1});
        vq.push_back('{4'b1100, 1'b1, 4'b0100, 1'b1});
        vq.push_back('{4'b1100, 1'b1, 4'b1000, 1'b1});
        vq.push_back('{4'b1100, 1'b0, 4'b0000, 1'b0});
        vq.push_back('{4'b1100, 1'b0, 4'b0000, 1'b0});
        vq.push_back('{4'b1100, 1'b1, 4'b0100, 1'b1});
        vq.push_back('{4'b0000, 1'b1, 4'b0000, 1'b1});
        vq.push_back('{4'b0000, 1'b1, 4'b0000, 1'b1});
        vq.push_back('{4'b0000, 1'b1, 4'b0000, 1'b1});
        foreach (vq[n]) begin
            req_valid = vq[n].valid;
            rsp_ready = vq[n].rdy;
            #1;
            check($sformatf("tbl%0d_ready", n), 32'(req_ready), 32'(vq[n].exp_ready));
            check($sformatf("tbl%0d_wren", n), 32'(add_wren), 32'(vq[n].exp_wren));
            step();
        end

        check("drain_sb_empty", 32'(sb.size()), 0);
        check("drain_busy", 32'(busy), 0);
        check("drain_valid", 32'(rsp_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
